// File: rtl/fu_sequencer_if.sv
// ============================================================================
//  Module   : fu_sequencer_if
//  Purpose  : Bundles the command, function-unit and response signals of the
//             function-unit sequencer. "master" is the sequencer side,
//             "slave" is the surrounding decode/unit/consumer side.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface fu_sequencer_if #(
    parameter int W    = 16,
    parameter int SH_W = 5
);
    // Command channel
    logic               cmd_valid;
    logic               cmd_ready;
    logic [2:0]         cmd_op;
    logic [W-1:0]       cmd_a;
    logic [W-1:0]       cmd_b;
    logic [SH_W-1:0]    cmd_sh;

    // Function-unit drive and result
    logic [W-1:0]       fu_a;
    logic [W-1:0]       fu_b;
    logic [4:0]         fu_fs;
    logic [SH_W-1:0]    fu_sh;
    logic [W-1:0]       fu_f;
    logic               fu_z;
    logic               fu_c;
    logic               fu_n;
    logic               fu_v;

    // Response channel and status
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*W-1:0]     rsp_data;
    logic [3:0]         status;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_sh,
        input  fu_f, fu_z, fu_c, fu_n, fu_v,
        input  rsp_ready,
        output cmd_ready,
        output fu_a, fu_b, fu_fs, fu_sh,
        output rsp_valid, rsp_data, status
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_sh,
        output fu_f, fu_z, fu_c, fu_n, fu_v,
        output rsp_ready,
        input  cmd_ready,
        input  fu_a, fu_b, fu_fs, fu_sh,
        input  rsp_valid, rsp_data, status
    );
endinterface

`default_nettype wire

// File: rtl/fu_sequencer.sv
// ============================================================================
//  Module   : fu_sequencer
//  Purpose  : Command-side master for the ALU/shifter function unit. Runs one
//             ALU/shift op per command, or a W-step shift-add multiply that
//             reuses the unit's adder, and returns result plus Z/C/N/V status.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fu_sequencer #(
    parameter int W    = 16,
    parameter int SH_W = 5
) (
    input  wire logic       clk,
    input  wire logic       rst,
    fu_sequencer_if.master  bus
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    localparam logic [4:0] FS_PASS = 5'b00000;
    localparam logic [4:0] FS_ADD  = 5'b00010;
    localparam logic [4:0] FS_SUB  = 5'b00101;
    localparam logic [4:0] FS_AND  = 5'b01000;
    localparam logic [4:0] FS_OR   = 5'b01010;
    localparam logic [4:0] FS_XOR  = 5'b01100;
    localparam logic [4:0] FS_SHL  = 5'b11000;
    localparam logic [4:0] FS_SHR  = 5'b10100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_MUL  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [SH_W-1:0]    sh_q, sh_d;
    logic [W-1:0]       acc_hi_q, acc_hi_d;
    logic [W-1:0]       mplr_q, mplr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]     rsp_data_q, rsp_data_d;
    logic [3:0]         status_q, status_d;

    logic [W-1:0]       fu_a;
    logic [W-1:0]       fu_b;
    logic [4:0]         fu_fs;
    logic [SH_W-1:0]    fu_sh;
    logic [2*W-1:0]     mul_step;

    // Drive the function unit from the current state and latched command
    always_comb begin
        fu_a  = '0;
        fu_b  = '0;
        fu_fs = FS_PASS;
        fu_sh = '0;
        case (state_q)
            S_EXEC: begin
                fu_a = a_q;
                fu_b = b_q;
                case (op_q)
                    OP_ADD:  fu_fs = FS_ADD;
                    OP_SUB:  fu_fs = FS_SUB;
                    OP_AND:  fu_fs = FS_AND;
                    OP_OR:   fu_fs = FS_OR;
                    OP_XOR:  fu_fs = FS_XOR;
                    OP_SHL: begin
                        fu_b  = a_q;
                        fu_sh = sh_q;
                        fu_fs = FS_SHL;
                    end
                    OP_SHR: begin
                        fu_b  = a_q;
                        fu_sh = sh_q;
                        fu_fs = FS_SHR;
                    end
                    default: fu_fs = FS_PASS;
                endcase
            end
            S_MUL: begin
                // Add the multiplicand into the high accumulator only when the
                // current multiplier bit is set; otherwise pass acc_hi through.
                fu_a  = acc_hi_q;
                fu_b  = a_q;
                fu_fs = mplr_q[0] ? FS_ADD : FS_PASS;
            end
            default: ;
        endcase
    end

    // One shift-add step: carry-out becomes the new MSB, the sum's LSB
    // shifts into the multiplier register as the next product bit.
    assign mul_step = {mplr_q[0] & bus.fu_c, bus.fu_f, mplr_q[W-1:1]};

    // Next-state, command capture, multiply datapath and result capture
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        sh_d       = sh_q;
        acc_hi_d   = acc_hi_q;
        mplr_d     = mplr_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        status_d   = status_q;
        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d     = bus.cmd_op;
                    a_d      = bus.cmd_a;
                    b_d      = bus.cmd_b;
                    sh_d     = bus.cmd_sh;
                    acc_hi_d = '0;
                    mplr_d   = bus.cmd_b;
                    cnt_d    = '0;
                    state_d  = (bus.cmd_op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                rsp_data_d = {{W{1'b0}}, bus.fu_f};
                status_d   = {bus.fu_z, bus.fu_c, bus.fu_n, bus.fu_v};
                state_d    = S_DONE;
            end
            S_MUL: begin
                {acc_hi_d, mplr_d} = mul_step;
                cnt_d              = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    rsp_data_d = mul_step;
                    status_d   = {(mul_step == '0), 1'b0, mul_step[2*W-1], 1'b0};
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any op in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sh_q       <= '0;
            acc_hi_q   <= '0;
            mplr_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            status_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sh_q       <= sh_d;
            acc_hi_q   <= acc_hi_d;
            mplr_q     <= mplr_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            status_q   <= status_d;
        end
    end

    assign bus.cmd_ready = (state_q == S_IDLE) & ~rst;
    assign bus.rsp_valid = (state_q == S_DONE);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.status    = status_q;
    assign bus.fu_a      = fu_a;
    assign bus.fu_b      = fu_b;
    assign bus.fu_fs     = fu_fs;
    assign bus.fu_sh     = fu_sh;

endmodule

`default_nettype wire

// File: tb/tb_fu_sequencer.sv
// ============================================================================
//  Module   : tb_fu_sequencer
//  Purpose  : Directed self-checking bench for fu_sequencer with a behavioural
//             model of the ALU/shifter function unit.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fu_sequencer;

    localparam int W    = 16;
    localparam int SH_W = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fu_sequencer_if #(.W(W), .SH_W(SH_W)) bus ();

    fu_sequencer #(.W(W), .SH_W(SH_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural function unit: F and flags from Bus_A/Bus_B/FS/SH
    always_comb begin
        logic [W:0] sum;
        sum      = '0;
        bus.fu_f = bus.fu_a;
        bus.fu_c = 1'b0;
        bus.fu_v = 1'b0;
        case (bus.fu_fs)
            5'b00010: begin
                sum      = {1'b0, bus.fu_a} + {1'b0, bus.fu_b};
                bus.fu_f = sum[W-1:0];
                bus.fu_c = sum[W];
                bus.fu_v = (bus.fu_a[W-1] == bus.fu_b[W-1]) && (sum[W-1] != bus.fu_a[W-1]);
            end
            5'b00101: begin
                sum      = {1'b0, bus.fu_a} + {1'b0, ~bus.fu_b} + 17'd1;
                bus.fu_f = sum[W-1:0];
                bus.fu_c = sum[W];
                bus.fu_v = (bus.fu_a[W-1] != bus.fu_b[W-1]) && (sum[W-1] != bus.fu_a[W-1]);
            end
            5'b01000: bus.fu_f = bus.fu_a & bus.fu_b;
            5'b01010: bus.fu_f = bus.fu_a | bus.fu_b;
            5'b01100: bus.fu_f = bus.fu_a ^ bus.fu_b;
            5'b11000: bus.fu_f = bus.fu_b << bus.fu_sh;
            5'b10100: bus.fu_f = bus.fu_b >> bus.fu_sh;
            default:  bus.fu_f = bus.fu_a;
        endcase
        bus.fu_z = (bus.fu_f == '0);
        bus.fu_n = bus.fu_f[W-1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Consume the pending response and confirm rsp_valid drops
    task automatic take_rsp(input string tag);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check({tag, ".valid_clr"}, 64'(bus.rsp_valid), 64'd0);
    endtask

    // Issue one command, then check latency, unit drive, result and status
    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [4:0] sh,
                          input logic [4:0] exp_fs, input logic [4:0] exp_sh,
                          input logic [31:0] exp_data, input logic [3:0] exp_status,
                          input int exp_lat);
        int g;
        int lat;
        logic [4:0] fs_seen;
        logic [4:0] sh_seen;
        g = 0;
        @(negedge clk);
        while (bus.cmd_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({tag, ".ready"}, 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sh    = sh;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'($urandom);
        bus.cmd_a     = 16'($urandom);
        bus.cmd_b     = 16'($urandom);
        bus.cmd_sh    = 5'($urandom);
        lat     = 0;
        fs_seen = '0;
        sh_seen = '0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                fs_seen = bus.fu_fs;
                sh_seen = bus.fu_sh;
            end
        end while (bus.rsp_valid !== 1'b1 && lat < 40);
        check({tag, ".fs"}, 64'(fs_seen), 64'(exp_fs));
        check({tag, ".sh"}, 64'(sh_seen), 64'(exp_sh));
        check({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        check({tag, ".data"}, 64'(bus.rsp_data), 64'(exp_data));
        check({tag, ".status"}, 64'(bus.status), 64'(exp_status));
        take_rsp(tag);
    endtask

    // Safety net in case a bounded wait is bypassed
    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_sh    = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.cmd_ready", 64'(bus.cmd_ready), 64'd0);
        check("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst.rsp_data", 64'(bus.rsp_data), 64'd0);
        check("rst.status", 64'(bus.status), 64'd0);
        check("rst.fu", 64'({bus.fu_a, bus.fu_b, bus.fu_fs, bus.fu_sh}), 64'd0);
        rst = 1'b0;
        #1;
        check("idle.cmd_ready", 64'(bus.cmd_ready), 64'd1);

        // ALU and shift ops
        do_cmd("add_ovf", 3'b000, 16'h7FFF, 16'h0001, 5'd0, 5'b00010, 5'd0, 32'h0000_8000, 4'b0011, 2);
        do_cmd("sub_eq",  3'b001, 16'h0005, 16'h0005, 5'd0, 5'b00101, 5'd0, 32'h0000_0000, 4'b1100, 2);
        do_cmd("and",     3'b010, 16'hF0F0, 16'hFF00, 5'd0, 5'b01000, 5'd0, 32'h0000_F000, 4'b0010, 2);
        do_cmd("or",      3'b011, 16'h0F00, 16'h00F0, 5'd0, 5'b01010, 5'd0, 32'h0000_0FF0, 4'b0000, 2);
        do_cmd("xor",     3'b100, 16'hAAAA, 16'hAAAA, 5'd0, 5'b01100, 5'd0, 32'h0000_0000, 4'b1000, 2);
        do_cmd("shl4",    3'b101, 16'h0001, 16'h5555, 5'd4, 5'b11000, 5'd4, 32'h0000_0010, 4'b0000, 2);
        do_cmd("shr15",   3'b110, 16'h8000, 16'h1234, 5'd15, 5'b10100, 5'd15, 32'h0000_0001, 4'b0000, 2);
        do_cmd("shl16",   3'b101, 16'h0001, 16'h0000, 5'd16, 5'b11000, 5'd16, 32'h0000_0000, 4'b1000, 2);

        // Multiply
        do_cmd("mul_max", 3'b111, 16'hFFFF, 16'hFFFF, 5'd0, 5'b00010, 5'd0, 32'hFFFE_0001, 4'b0010, 17);
        do_cmd("mul_zero",3'b111, 16'h0000, 16'h1234, 5'd0, 5'b00000, 5'd0, 32'h0000_0000, 4'b1000, 17);
        check("status_hold_idle", 64'(bus.status), 64'b1000);
        do_cmd("mul_3x5", 3'b111, 16'h0003, 16'h0005, 5'd0, 5'b00010, 5'd0, 32'h0000_000F, 4'b0000, 17);

        // Backpressure: ADD 3+4 held in DONE while a second command waits
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b000;
        bus.cmd_a     = 16'h0003;
        bus.cmd_b     = 16'h0004;
        @(posedge clk);
        #1;
        bus.cmd_op = 3'b001;
        bus.cmd_a  = 16'h0009;
        bus.cmd_b  = 16'h0001;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp.valid", 64'(bus.rsp_valid), 64'd1);
            check("bp.data", 64'(bus.rsp_data), 64'h7);
            check("bp.cmd_ready", 64'(bus.cmd_ready), 64'd0);
        end
        check("bp.status", 64'(bus.status), 64'b0000);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("bp.valid_clr", 64'(bus.rsp_valid), 64'd0);
        check("bp.ready_after", 64'(bus.cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("bp2.valid", 64'(bus.rsp_valid), 64'd1);
        check("bp2.data", 64'(bus.rsp_data), 64'h8);
        check("bp2.status", 64'(bus.status), 64'b0100);
        take_rsp("bp2");

        // Reset in the middle of a multiply
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b111;
        bus.cmd_a     = 16'hFFFF;
        bus.cmd_b     = 16'hFFFF;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mrst.valid", 64'(bus.rsp_valid), 64'd0);
        check("mrst.status", 64'(bus.status), 64'd0);
        check("mrst.data", 64'(bus.rsp_data), 64'd0);
        check("mrst.fu", 64'({bus.fu_a, bus.fu_b, bus.fu_fs, bus.fu_sh}), 64'd0);
        check("mrst.cmd_ready", 64'(bus.cmd_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst.ready_after", 64'(bus.cmd_ready), 64'd1);
        repeat (3) @(negedge clk);
        check("mrst.discarded", 64'(bus.rsp_valid), 64'd0);
        do_cmd("add_post", 3'b000, 16'h1234, 16'h1111, 5'd0, 5'b00010, 5'd0, 32'h0000_2345, 4'b0000, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
